// File: rtl/seq_comparator.sv
// Bit-serial MSB-first magnitude comparator for unsigned or two's-complement operands.
// Start/busy/done handshake; the six result flags are registered and held until the next done.
module seq_comparator #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] valA,
    input  logic [WIDTH-1:0] valB,
    output logic             busy,
    output logic             done,
    output logic             aGTb,
    output logic             aGEb,
    output logic             aLTb,
    output logic             aLEb,
    output logic             aEQb,
    output logic             aNEb
);

    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             diff_q, diff_d;
    logic             gt_q, gt_d;
    logic [5:0]       flags_q, flags_d;   // {GT, GE, LT, LE, EQ, NE}

    logic bit_a, bit_b, hit;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        idx_d   = idx_q;
        diff_d  = diff_q;
        gt_d    = gt_q;
        flags_d = flags_q;
        bit_a   = a_q[idx_q];
        bit_b   = b_q[idx_q];
        hit     = ~diff_q & (bit_a ^ bit_b);

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = valA;
                    b_d     = valB;
                    sgn_d   = signed_mode;
                    idx_d   = IW'(WIDTH - 1);
                    diff_d  = 1'b0;
                    gt_d    = 1'b0;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                // Only the first differing bit decides; the sign bit has inverted weight in signed mode.
                if (hit) begin
                    diff_d = 1'b1;
                    if (sgn_q && (idx_q == IW'(WIDTH - 1)))
                        gt_d = ~bit_a & bit_b;
                    else
                        gt_d = bit_a & ~bit_b;
                end
                if ((EARLY_EXIT && hit) || (idx_q == '0)) begin
                    state_d = DONE;
                    flags_d = {diff_d & gt_d,
                               (diff_d & gt_d) | ~diff_d,
                               diff_d & ~gt_d,
                               (diff_d & ~gt_d) | ~diff_d,
                               ~diff_d,
                               diff_d};
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            idx_q   <= '0;
            diff_q  <= 1'b0;
            gt_q    <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            idx_q   <= idx_d;
            diff_q  <= diff_d;
            gt_q    <= gt_d;
            flags_q <= flags_d;
        end
    end

    assign busy = (state_q == COMPARE);
    assign done = (state_q == DONE);
    assign {aGTb, aGEb, aLTb, aLEb, aEQb, aNEb} = flags_q;

endmodule

// File: tb/tb_seq_comparator.sv
// Directed bench for seq_comparator: 8-bit vectors with both exit modes, handshake and
// reset corner cases, and an exhaustive 3-bit sweep against a behavioural model.
module tb_seq_comparator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start8, start3, sgn;
    logic [7:0] a8, b8;
    logic [2:0] a3, b3;
    logic [3:0] busy_v, done_v;
    logic [3:0][5:0] fl;     // per instance {GT, GE, LT, LE, EQ, NE}
    logic [3:0][5:0] prev;

    int checks = 0;
    int errors = 0;

    // 0: W8/EE1, 1: W8/EE0, 2: W3/EE1, 3: W3/EE0
    seq_comparator #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_w8_ee1 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sgn), .valA(a8), .valB(b8),
        .busy(busy_v[0]), .done(done_v[0]), .aGTb(fl[0][5]), .aGEb(fl[0][4]),
        .aLTb(fl[0][3]), .aLEb(fl[0][2]), .aEQb(fl[0][1]), .aNEb(fl[0][0]));
    seq_comparator #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_w8_ee0 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sgn), .valA(a8), .valB(b8),
        .busy(busy_v[1]), .done(done_v[1]), .aGTb(fl[1][5]), .aGEb(fl[1][4]),
        .aLTb(fl[1][3]), .aLEb(fl[1][2]), .aEQb(fl[1][1]), .aNEb(fl[1][0]));
    seq_comparator #(.WIDTH(3), .EARLY_EXIT(1'b1)) u_w3_ee1 (
        .clk(clk), .rst(rst), .start(start3), .signed_mode(sgn), .valA(a3), .valB(b3),
        .busy(busy_v[2]), .done(done_v[2]), .aGTb(fl[2][5]), .aGEb(fl[2][4]),
        .aLTb(fl[2][3]), .aLEb(fl[2][2]), .aEQb(fl[2][1]), .aNEb(fl[2][0]));
    seq_comparator #(.WIDTH(3), .EARLY_EXIT(1'b0)) u_w3_ee0 (
        .clk(clk), .rst(rst), .start(start3), .signed_mode(sgn), .valA(a3), .valB(b3),
        .busy(busy_v[3]), .done(done_v[3]), .aGTb(fl[3][5]), .aGEb(fl[3][4]),
        .aLTb(fl[3][3]), .aLEb(fl[3][2]), .aEQb(fl[3][1]), .aNEb(fl[3][0]));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        int         lat;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one compare on the 8-bit or 3-bit pair and check latency, flags and handshake.
    task automatic run_cmp(input bit wide, input logic [7:0] a, input logic [7:0] b,
                           input logic s, input int lat1, input int lat0, input logic [5:0] exp);
        int base;
        int got[2];
        logic [5:0] cap[2];
        string tag;
        base = wide ? 0 : 2;
        tag = $sformatf("w%0d a=%0h b=%0h s=%0d", wide ? 8 : 3, a, b, s);
        got[0] = 0;
        got[1] = 0;
        cap[0] = '0;
        cap[1] = '0;
        sgn = s;
        if (wide) begin
            a8 = a; b8 = b; start8 = 1'b1;
        end else begin
            a3 = a[2:0]; b3 = b[2:0]; start3 = 1'b1;
        end
        tick();
        start8 = 1'b0;
        start3 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            for (int j = 0; j < 2; j++) begin
                if (c == 1) begin
                    chk({"busy_c1 ", tag}, int'(busy_v[base+j]), 1);
                    chk({"flags_held ", tag}, int'(fl[base+j]), int'(prev[base+j]));
                end
                if (done_v[base+j]) begin
                    if (got[j] != 0) chk({"done_twice ", tag}, c, got[j]);
                    else begin
                        got[j] = c;
                        cap[j] = fl[base+j];
                    end
                end
            end
            if (got[0] != 0 && got[1] != 0 && c > got[0] && c > got[1]) break;
            tick();
        end
        chk({"lat_ee1 ", tag}, got[0], lat1);
        chk({"lat_ee0 ", tag}, got[1], lat0);
        chk({"flags_ee1 ", tag}, int'(cap[0]), int'(exp));
        chk({"flags_ee0 ", tag}, int'(cap[1]), int'(exp));
        prev[base]   = exp;
        prev[base+1] = exp;
    endtask

    initial begin
        int got0, got1, ndone;
        logic [2:0] av, bv;
        logic gt, eq;
        int k, lat1;

        vecs[0]  = '{8'h80, 8'h7F, 1'b0, 2, 6'b110001};
        vecs[1]  = '{8'h80, 8'h7F, 1'b1, 2, 6'b001101};
        vecs[2]  = '{8'h5A, 8'h5A, 1'b0, 9, 6'b010110};
        vecs[3]  = '{8'h5A, 8'h5A, 1'b1, 9, 6'b010110};
        vecs[4]  = '{8'h80, 8'h00, 1'b0, 2, 6'b110001};
        vecs[5]  = '{8'h01, 8'h00, 1'b0, 9, 6'b110001};
        vecs[6]  = '{8'h81, 8'h80, 1'b0, 9, 6'b110001};
        vecs[7]  = '{8'h00, 8'hFF, 1'b1, 2, 6'b110001};
        vecs[8]  = '{8'h7F, 8'h80, 1'b0, 2, 6'b001101};
        vecs[9]  = '{8'h3C, 8'h3D, 1'b1, 9, 6'b001101};
        vecs[10] = '{8'hF0, 8'hE0, 1'b1, 5, 6'b110001};
        vecs[11] = '{8'h12, 8'h34, 1'b0, 4, 6'b001101};

        rst = 1'b1; start8 = 1'b0; start3 = 1'b0; sgn = 1'b0;
        a8 = '0; b8 = '0; a3 = '0; b3 = '0;
        prev = '0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_busy i%0d", i), int'(busy_v[i]), 0);
            chk($sformatf("reset_done i%0d", i), int'(done_v[i]), 0);
            chk($sformatf("reset_flags i%0d", i), int'(fl[i]), 0);
        end

        for (int i = 0; i < 12; i++)
            run_cmp(1'b1, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].lat, 9, vecs[i].exp);

        // start re-pulsed mid-compare with new operands must be ignored
        sgn = 1'b0; a8 = 8'h5A; b8 = 8'h5A; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        got0 = 0; got1 = 0; ndone = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 3) begin a8 = 8'h11; b8 = 8'h22; sgn = 1'b1; start8 = 1'b1; end
            if (c == 4) start8 = 1'b0;
            if (done_v[0]) begin ndone++; if (got0 == 0) got0 = c; end
            if (done_v[1] && got1 == 0) got1 = c;
            if (got0 != 0 && got1 != 0) break;
            tick();
        end
        chk("ignore_start lat_ee1", got0, 9);
        chk("ignore_start lat_ee0", got1, 9);
        chk("ignore_start ndone", ndone, 1);
        chk("ignore_start flags_ee1", int'(fl[0]), int'(6'b010110));
        chk("ignore_start flags_ee0", int'(fl[1]), int'(6'b010110));
        // start raised during DONE is dropped; held into the following cycle it is taken
        a8 = 8'h80; b8 = 8'h7F; sgn = 1'b0; start8 = 1'b1;
        tick();
        chk("start_in_done busy", int'(busy_v[0]), 0);
        tick();
        start8 = 1'b0;
        chk("start_after_done busy", int'(busy_v[0]), 1);
        tick();
        chk("start_after_done done", int'(done_v[0]), 1);
        chk("start_after_done flags", int'(fl[0]), int'(6'b110001));
        got1 = 0;
        for (int c = 0; c < 12 && got1 == 0; c++) begin
            if (done_v[1]) got1 = 1;
            else tick();
        end
        chk("start_after_done ee0 done", got1, 1);
        chk("start_after_done ee0 flags", int'(fl[1]), int'(6'b110001));
        tick();
        prev[0] = 6'b110001;
        prev[1] = 6'b110001;

        // reset mid-compare, together with start, aborts with no done
        a8 = 8'h5A; b8 = 8'h5A; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        rst = 1'b1; start8 = 1'b1;
        tick();
        rst = 1'b0; start8 = 1'b0;
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("abort_busy i%0d", j), int'(busy_v[j]), 0);
            chk($sformatf("abort_done i%0d", j), int'(done_v[j]), 0);
            chk($sformatf("abort_flags i%0d", j), int'(fl[j]), 0);
        end
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            if (done_v[0] || done_v[1]) ndone++;
            tick();
        end
        chk("abort_no_done", ndone, 0);
        prev[0] = '0;
        prev[1] = '0;

        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 8; a++) begin
                for (int b = 0; b < 8; b++) begin
                    av = 3'(a);
                    bv = 3'(b);
                    eq = (av == bv);
                    gt = (s != 0) ? ($signed(av) > $signed(bv)) : (av > bv);
                    k = 0;
                    for (int i = 2; i >= 0; i--)
                        if (k == 0 && av[i] != bv[i]) k = 3 - i;
                    lat1 = (k != 0) ? k + 1 : 4;
                    run_cmp(1'b0, {5'b0, av}, {5'b0, bv}, s[0], lat1, 4,
                            {gt, gt | eq, ~gt & ~eq, ~gt, eq, ~eq});
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
